// File: rtl/rarp_tx_serializer.sv
// rtl/rarp_tx_serializer.sv - ARP/RARP header capture and MSB-first DATA_W-bit beat serialiser
module rarp_tx_serializer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       hdr_type,
    input  logic [15:0]       proto_type,
    input  logic [7:0]        hdw_length,
    input  logic [7:0]        pro_length,
    input  logic [15:0]       operation,
    input  logic [47:0]       send_hdr_addr,
    input  logic [31:0]       send_ip_addr,
    input  logic [47:0]       target_hdr_addr,
    input  logic [31:0]       target_ip_addr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              tx_busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int BEATS = 224 / DATA_W;
    localparam int BCW   = $clog2(BEATS);

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_width
        $error("rarp_tx_serializer: DATA_W must be 8, 16 or 32");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state;
    logic [223:0]   shift;
    logic [BCW-1:0] beat;

    // The shift register empties itself as beats leave, so tx_data reads zero when idle.
    assign tx_data = shift[223 -: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            beat      <= '0;
            in_ready  <= 1'b1;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            tx_busy   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shift    <= {hdr_type, proto_type, hdw_length, pro_length, operation,
                                     send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr};
                        beat     <= '0;
                        state    <= SEND;
                        in_ready <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_busy  <= 1'b1;
                        tx_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        shift <= shift << DATA_W;
                        if (beat == BCW'(BEATS - 1)) begin
                            state     <= IDLE;
                            beat      <= '0;
                            in_ready  <= 1'b1;
                            tx_valid  <= 1'b0;
                            tx_last   <= 1'b0;
                            tx_busy   <= 1'b0;
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end else begin
                            beat    <= beat + BCW'(1);
                            tx_last <= (beat == BCW'(BEATS - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
